round_robin_arbiter_8: RTL and testbench

ROUND_ROBIN_ARBITER_8 -- requirements
Module: round_robin_arbiter_8

---
 rtl/round_robin_arbiter_8.sv | 107 ++++++++++
 tb/tb_round_robin_arbiter_8.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a per-grant hold limit.
// A holder keeps the grant while it requests, up to MAX_HOLD cycles, then the search resumes after it.
module round_robin_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [7:0]       grant_n;
  logic [2:0]       idx_n;
  logic [2:0]       ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic             timeout_n;
  logic [2:0]       search_start;
  logic [3:0]       pick;

  // Returns {found, index} of the first set request at or after start, wrapping mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    search_start = (state == BUSY) ? grant_idx + 3'd1 : ptr;
    pick         = rr_pick(req, search_start);

    state_n    = state;
    grant_n    = grant;
    idx_n      = grant_idx;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;

    case (state)
      IDLE: begin
        if (pick[3]) begin
          state_n    = BUSY;
          grant_n    = 8'b1 << pick[2:0];
          idx_n      = pick[2:0];
          hold_cnt_n = '0;
        end
      end
      BUSY: begin
        if (!req[grant_idx] || hold_cnt == HOLD_LAST) begin
          // Release wins over expiry: a pulse only when the holder is still requesting.
          timeout_n  = req[grant_idx];
          ptr_n      = search_start;
          hold_cnt_n = '0;
          if (pick[3]) begin
            grant_n = 8'b1 << pick[2:0];
            idx_n   = pick[2:0];
          end else begin
            state_n = IDLE;
            grant_n = '0;
            idx_n   = '0;
          end
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      timeout   <= timeout_n;
    end
  end

  assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Bench for round_robin_arbiter_8: two instances (MAX_HOLD=2 and 16) share stimulus and are
// checked every cycle against an integer reference model, plus directed scenario checks.
module tb_round_robin_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant_o [2];
  logic [2:0] gidx_o  [2];
  logic       gvld_o  [2];
  logic       tout_o  [2];

  int total;
  int bad;

  int mh     [2] = '{2, 16};
  int m_busy [2];
  int m_idx  [2];
  int m_ptr  [2];
  int m_held [2];
  int m_to   [2];

  round_robin_arbiter_8 #(.MAX_HOLD(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_o[0]), .grant_idx(gidx_o[0]), .grant_valid(gvld_o[0]), .timeout(tout_o[0])
  );

  round_robin_arbiter_8 #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_o[1]), .grant_idx(gidx_o[1]), .grant_valid(gvld_o[1]), .timeout(tout_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
    end
  endtask

  // One clock edge of the reference: m_held counts cycles the current holder has owned the grant.
  task automatic model_edge(input logic [7:0] r);
    int p;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 0;
      if (m_busy[k] == 0) begin
        p = pick(r, m_ptr[k]);
        if (p >= 0) begin
          m_busy[k] = 1; m_idx[k] = p; m_held[k] = 1;
        end
      end else if (!r[m_idx[k]] || m_held[k] == mh[k]) begin
        m_to[k]  = r[m_idx[k]] ? 1 : 0;
        m_ptr[k] = (m_idx[k] + 1) % 8;
        p = pick(r, m_ptr[k]);
        if (p >= 0) begin
          m_idx[k] = p; m_held[k] = 1;
        end else begin
          m_busy[k] = 0; m_idx[k] = 0; m_held[k] = 0;
        end
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    logic [7:0] eg;
    for (int k = 0; k < 2; k++) begin
      eg = (m_busy[k] != 0) ? (8'b1 << m_idx[k]) : 8'h00;
      chk($sformatf("%s_grant_d%0d", tag, k), 32'(grant_o[k]), 32'(eg));
      chk($sformatf("%s_idx_d%0d", tag, k), 32'(gidx_o[k]), (m_busy[k] != 0) ? 32'(m_idx[k]) : 32'd0);
      chk($sformatf("%s_vld_d%0d", tag, k), 32'(gvld_o[k]), 32'(m_busy[k]));
      chk($sformatf("%s_to_d%0d", tag, k), 32'(tout_o[k]), 32'(m_to[k]));
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rst_v, input string tag);
    @(negedge clk);
    req   = r;
    rst_n = rst_v;
    if (!rst_v) model_clear();
    @(posedge clk);
    model_edge(r);
    #1;
    cmp_all(tag);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then holds it for two edges.
  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    req = r;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    cmp_all("rst_async");
    step(r, 1'b0, "rst_hold");
    step(r, 1'b0, "rst_hold");
  endtask

  initial begin
    logic [7:0] cur;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    model_clear();
    #1;
    chk("reset_grant", 32'(grant_o[1]), 32'h0);
    chk("reset_vld", 32'(gvld_o[1]), 32'h0);
    step(8'hFF, 1'b0, "reset_req_ignored");
    chk("reset_req_grant", 32'(grant_o[0]), 32'h0);

    // Single request, then release to idle.
    step(8'h04, 1'b1, "single");
    chk("single_grant", 32'(grant_o[1]), 32'h04);
    chk("single_idx", 32'(gidx_o[1]), 32'd2);
    chk("single_vld", 32'(gvld_o[1]), 32'd1);
    step(8'h00, 1'b1, "single_rel");
    chk("single_rel_grant", 32'(grant_o[1]), 32'h0);
    chk("single_rel_vld", 32'(gvld_o[1]), 32'd0);

    // Full rotation with MAX_HOLD=2, including the 7->0 wrap.
    do_reset(8'h00);
    for (int i = 0; i <= 16; i++) begin
      step(8'hFF, 1'b1, "rot");
      chk("rot_idx", 32'(gidx_o[0]), 32'((i / 2) % 8));
      chk("rot_to", 32'(tout_o[0]), (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Back-to-back release without idle bubble.
    do_reset(8'h00);
    step(8'h08, 1'b1, "b2b");
    chk("b2b_idx3", 32'(gidx_o[1]), 32'd3);
    step(8'hA8, 1'b1, "b2b");
    chk("b2b_hold3", 32'(gidx_o[1]), 32'd3);
    step(8'hA0, 1'b1, "b2b");
    chk("b2b_idx5", 32'(gidx_o[1]), 32'd5);
    chk("b2b_vld5", 32'(gvld_o[1]), 32'd1);
    step(8'h80, 1'b1, "b2b");
    chk("b2b_idx7", 32'(gidx_o[1]), 32'd7);
    step(8'h01, 1'b1, "b2b");
    chk("b2b_wrap0", 32'(grant_o[1]), 32'h01);
    step(8'h00, 1'b1, "b2b");
    chk("b2b_idle", 32'(gvld_o[1]), 32'd0);

    // Sole requester across a MAX_HOLD=16 expiry: regranted with no gap.
    do_reset(8'h00);
    for (int i = 0; i < 20; i++) begin
      step(8'h10, 1'b1, "sole");
      chk("sole_grant", 32'(grant_o[1]), 32'h10);
      chk("sole_to", 32'(tout_o[1]), (i == 16) ? 32'd1 : 32'd0);
    end

    // No preemption, then release on the would-be timeout edge.
    do_reset(8'h00);
    step(8'h40, 1'b1, "nopre");
    for (int i = 0; i < 15; i++) begin
      step(8'h42, 1'b1, "nopre");
      chk("nopre_idx", 32'(gidx_o[1]), 32'd6);
    end
    step(8'h02, 1'b1, "relto");
    chk("relto_to", 32'(tout_o[1]), 32'd0);
    chk("relto_idx", 32'(gidx_o[1]), 32'd1);

    // Reset in the middle of a grant; arbitration restarts from index 0.
    do_reset(8'h00);
    step(8'h20, 1'b1, "midrst");
    chk("midrst_idx5", 32'(gidx_o[1]), 32'd5);
    do_reset(8'h21);
    chk("midrst_grant0", 32'(grant_o[1]), 32'h0);
    chk("midrst_to0", 32'(tout_o[1]), 32'd0);
    step(8'h21, 1'b1, "midrst_after");
    chk("midrst_after_idx", 32'(gidx_o[1]), 32'd0);
    chk("midrst_after_grant", 32'(grant_o[0]), 32'h01);

    // Randomized traffic with occasional resets.
    cur = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(cur);
      case ($urandom_range(0, 5))
        0: cur = 8'($urandom);
        1: cur = cur & 8'($urandom);
        2: cur = cur | (8'b1 << $urandom_range(0, 7));
        default: ;
      endcase
      step(cur, 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
